// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the 16x16 register file.
// Two producers (memory-load return and ALU) push into an in-order queue.
// At most one entry per cycle drains into a registered write port.
// Pending writes are forwarded combinationally to the A/B read ports.
module regfile_wb_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       Reset_n,
  input  logic                       AluValid,
  input  logic [ADDR_W-1:0]          AluAddr,
  input  logic [DATA_W-1:0]          AluData,
  input  logic                       MemValid,
  input  logic [ADDR_W-1:0]          MemAddr,
  input  logic [DATA_W-1:0]          MemData,
  output logic                       Ready,
  output logic                       RfWrite,
  output logic [ADDR_W-1:0]          RfWriteAddr,
  output logic [DATA_W-1:0]          RfDataIn,
  input  logic [ADDR_W-1:0]          ReadAddrA,
  input  logic [ADDR_W-1:0]          ReadAddrB,
  output logic                       FwdHitA,
  output logic [DATA_W-1:0]          FwdDataA,
  output logic                       FwdHitB,
  output logic [DATA_W-1:0]          FwdDataB,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH+1);

  // Queue storage; contents are only meaningful between head and tail.
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];

  logic [PtrW-1:0] headQ, headD;
  logic [PtrW-1:0] tailQ, tailD;
  logic [CntW-1:0] countQ, countD;

  logic readyInt;
  logic pushMem;
  logic pushAlu;
  logic pop;
  logic [PtrW-1:0] aluSlot;

  // Two free slots guarantee a double push cannot overflow, even without a pop.
  assign readyInt = (countQ <= CntW'(DEPTH - 2));
  assign Ready    = readyInt;
  assign Count    = countQ;

  // Writes to register 0 are accepted but dropped: it is hardwired to zero.
  assign pushMem = MemValid && readyInt && (MemAddr != '0);
  assign pushAlu = AluValid && readyInt && (AluAddr != '0);
  assign pop     = (countQ != '0);

  // Mem goes first so the ALU value is the newer entry on a shared edge.
  assign aluSlot = tailQ + PtrW'(pushMem);

  // Next-state for pointers and occupancy; pointers wrap naturally (power of 2).
  always_comb begin
    headD  = headQ + PtrW'(pop);
    tailD  = tailQ + PtrW'(pushMem) + PtrW'(pushAlu);
    countD = countQ + CntW'(pushMem) + CntW'(pushAlu) - CntW'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
    end
  end

  // Queue storage writes; the two slots differ whenever both producers push.
  always_ff @(posedge CLK) begin
    if (pushMem) begin
      addrMem[tailQ] <= MemAddr;
      dataMem[tailQ] <= MemData;
    end
    if (pushAlu) begin
      addrMem[aluSlot] <= AluAddr;
      dataMem[aluSlot] <= AluData;
    end
  end

  // Output register: pops the head (pre-edge occupancy), address/data hold when idle.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      RfWrite     <= 1'b0;
      RfWriteAddr <= '0;
      RfDataIn    <= '0;
    end else if (pop) begin
      RfWrite     <= 1'b1;
      RfWriteAddr <= addrMem[headQ];
      RfDataIn    <= dataMem[headQ];
    end else begin
      RfWrite     <= 1'b0;
    end
  end

  // Forwarding: scan output register first, then queue oldest to newest so the
  // last match (newest) wins.
  always_comb begin
    logic [PtrW-1:0] slot;
    slot     = '0;
    FwdHitA  = 1'b0;
    FwdDataA = '0;
    FwdHitB  = 1'b0;
    FwdDataB = '0;

    if (RfWrite && (RfWriteAddr == ReadAddrA) && (ReadAddrA != '0)) begin
      FwdHitA  = 1'b1;
      FwdDataA = RfDataIn;
    end
    if (RfWrite && (RfWriteAddr == ReadAddrB) && (ReadAddrB != '0)) begin
      FwdHitB  = 1'b1;
      FwdDataB = RfDataIn;
    end

    for (int i = 0; i < DEPTH; i++) begin
      slot = headQ + PtrW'(i);
      if (CntW'(i) < countQ) begin
        if ((addrMem[slot] == ReadAddrA) && (ReadAddrA != '0)) begin
          FwdHitA  = 1'b1;
          FwdDataA = dataMem[slot];
        end
        if ((addrMem[slot] == ReadAddrB) && (ReadAddrB != '0)) begin
          FwdHitB  = 1'b1;
          FwdDataB = dataMem[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Bench for regfile_wb_buffer: directed vector table, multi-cycle sequences
// (backpressure, ordered fill, mid-operation reset) and random stimulus
// checked against a queue-based reference model.
module tb_regfile_wb_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        AluValid = 1'b0;
  logic [3:0]  AluAddr = '0;
  logic [15:0] AluData = '0;
  logic        MemValid = 1'b0;
  logic [3:0]  MemAddr = '0;
  logic [15:0] MemData = '0;
  logic        Ready;
  logic        RfWrite;
  logic [3:0]  RfWriteAddr;
  logic [15:0] RfDataIn;
  logic [3:0]  ReadAddrA = '0;
  logic [3:0]  ReadAddrB = '0;
  logic        FwdHitA;
  logic [15:0] FwdDataA;
  logic        FwdHitB;
  logic [15:0] FwdDataB;
  logic [2:0]  Count;

  always #5 CLK = ~CLK;

  regfile_wb_buffer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .AluValid   (AluValid),
    .AluAddr    (AluAddr),
    .AluData    (AluData),
    .MemValid   (MemValid),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .Ready      (Ready),
    .RfWrite    (RfWrite),
    .RfWriteAddr(RfWriteAddr),
    .RfDataIn   (RfDataIn),
    .ReadAddrA  (ReadAddrA),
    .ReadAddrB  (ReadAddrB),
    .FwdHitA    (FwdHitA),
    .FwdDataA   (FwdDataA),
    .FwdHitB    (FwdHitB),
    .FwdDataB   (FwdDataB),
    .Count      (Count)
  );

  // Register file attached to the write port.
  logic [15:0] rfMem [16];
  always @(posedge CLK) begin
    if (RfWrite) rfMem[RfWriteAddr] <= RfDataIn;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md,
                       input logic [3:0] ra, input logic [3:0] rb);
    AluValid = av; AluAddr = aa; AluData = ad;
    MemValid = mv; MemAddr = ma; MemData = md;
    ReadAddrA = ra; ReadAddrB = rb;
  endtask

  typedef struct {
    logic        aluV;
    logic [3:0]  aluA;
    logic [15:0] aluD;
    logic        memV;
    logic [3:0]  memA;
    logic [15:0] memD;
    logic [3:0]  rdA;
    logic [3:0]  rdB;
    logic        eRdy;
    logic        eWr;
    logic [3:0]  eWa;
    logic [15:0] eWd;
    logic [2:0]  eCnt;
    logic        eHa;
    logic [15:0] eDa;
    logic        eHb;
    logic [15:0] eDb;
  } vec_t;

  vec_t vecs [15];

  // Reference model: ordered list of pending {addr,data} plus the output stage.
  logic [19:0] mq [$];
  logic        mOutV;
  logic [3:0]  mOutA;
  logic [15:0] mOutD;

  task automatic modelStep();
    logic rdy;
    logic [19:0] e;
    rdy = (mq.size() <= DEPTH - 2);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      mOutV = 1'b1;
      mOutA = e[19:16];
      mOutD = e[15:0];
    end else begin
      mOutV = 1'b0;
    end
    if (rdy && MemValid && MemAddr != 4'd0) mq.push_back({MemAddr, MemData});
    if (rdy && AluValid && AluAddr != 4'd0) mq.push_back({AluAddr, AluData});
  endtask

  task automatic modelFwd(input logic [3:0] ra, output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d = 16'h0;
    if (ra != 4'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i][19:16] == ra) begin
          hit = 1'b1;
          d = mq[i][15:0];
        end
      end
      if (!hit && mOutV && mOutA == ra) begin
        hit = 1'b1;
        d = mOutD;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0] expQ [$];
    logic [19:0] wrLog [$];
    logic [19:0] expE;
    logic        mh;
    logic [15:0] md;
    int s;
    int a;

    // rows: alu(v,a,d) mem(v,a,d) rdA rdB | rdy wr wa wd cnt hA dA hB dB
    vecs[0]  = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd5, 4'd0,
                 1'b1, 1'b0, 4'd0, 16'h0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};
    vecs[1]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd0,
                 1'b1, 1'b0, 4'd0, 16'h0, 3'd1, 1'b1, 16'h1234, 1'b0, 16'h0};
    vecs[2]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd0,
                 1'b1, 1'b1, 4'd5, 16'h1234, 3'd0, 1'b1, 16'h1234, 1'b0, 16'h0};
    vecs[3]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5,
                 1'b1, 1'b0, 4'd5, 16'h1234, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};
    vecs[4]  = '{1'b1, 4'd3, 16'hBBBB, 1'b1, 4'd3, 16'hAAAA, 4'd3, 4'd5,
                 1'b1, 1'b0, 4'd5, 16'h1234, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};
    vecs[5]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3,
                 1'b1, 1'b0, 4'd5, 16'h1234, 3'd2, 1'b1, 16'hBBBB, 1'b1, 16'hBBBB};
    vecs[6]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd4,
                 1'b1, 1'b1, 4'd3, 16'hAAAA, 3'd1, 1'b1, 16'hBBBB, 1'b0, 16'h0};
    vecs[7]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3,
                 1'b1, 1'b1, 4'd3, 16'hBBBB, 3'd0, 1'b1, 16'hBBBB, 1'b1, 16'hBBBB};
    vecs[8]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 4'd0, 4'd3,
                 1'b1, 1'b0, 4'd3, 16'hBBBB, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};
    vecs[9]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0,
                 1'b1, 1'b0, 4'd3, 16'hBBBB, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};
    vecs[10] = '{1'b1, 4'd9, 16'h0909, 1'b1, 4'd7, 16'h0707, 4'd7, 4'd9,
                 1'b1, 1'b0, 4'd3, 16'hBBBB, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};
    vecs[11] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd9,
                 1'b1, 1'b0, 4'd3, 16'hBBBB, 3'd2, 1'b1, 16'h0707, 1'b1, 16'h0909};
    vecs[12] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd9,
                 1'b1, 1'b1, 4'd7, 16'h0707, 3'd1, 1'b1, 16'h0707, 1'b1, 16'h0909};
    vecs[13] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd9,
                 1'b1, 1'b1, 4'd9, 16'h0909, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0909};
    vecs[14] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd9,
                 1'b1, 1'b0, 4'd9, 16'h0909, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0};

    // Reset state
    #1;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_wr", 32'(RfWrite), 32'd0);
    check("rst_waddr", 32'(RfWriteAddr), 32'd0);
    check("rst_wdata", 32'(RfDataIn), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_hitA", 32'(FwdHitA), 32'd0);
    check("rst_hitB", 32'(FwdHitB), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;

    // Directed vector table: single write, same-edge pair, address 0, two addresses
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      drive(vecs[i].aluV, vecs[i].aluA, vecs[i].aluD, vecs[i].memV, vecs[i].memA,
            vecs[i].memD, vecs[i].rdA, vecs[i].rdB);
      #1;
      check($sformatf("v%0d_ready", i), 32'(Ready), 32'(vecs[i].eRdy));
      check($sformatf("v%0d_wr", i), 32'(RfWrite), 32'(vecs[i].eWr));
      check($sformatf("v%0d_waddr", i), 32'(RfWriteAddr), 32'(vecs[i].eWa));
      check($sformatf("v%0d_wdata", i), 32'(RfDataIn), 32'(vecs[i].eWd));
      check($sformatf("v%0d_count", i), 32'(Count), 32'(vecs[i].eCnt));
      check($sformatf("v%0d_hitA", i), 32'(FwdHitA), 32'(vecs[i].eHa));
      check($sformatf("v%0d_dataA", i), 32'(FwdDataA), 32'(vecs[i].eDa));
      check($sformatf("v%0d_hitB", i), 32'(FwdHitB), 32'(vecs[i].eHb));
      check($sformatf("v%0d_dataB", i), 32'(FwdDataB), 32'(vecs[i].eDb));
    end

    // Backpressure: both producers always requesting, distinct nonzero addresses
    s = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      if (RfWrite) begin
        expE = (expQ.size() > 0) ? expQ.pop_front() : 20'hFFFFF;
        check($sformatf("bp%0d_entry", k), 32'({RfWriteAddr, RfDataIn}), 32'(expE));
      end
      check($sformatf("bp%0d_count", k), 32'(Count),
            (k == 0) ? 32'd0 : ((k % 2 == 1) ? 32'd2 : 32'd3));
      check($sformatf("bp%0d_ready", k), 32'(Ready), (k == 0 || k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("bp%0d_wr", k), 32'(RfWrite), (k >= 2) ? 32'd1 : 32'd0);
      drive(1'b1, 4'((s + 1) % 15 + 1), 16'(16'hC000 + s + 1),
            1'b1, 4'(s % 15 + 1), 16'(16'hC000 + s), 4'd0, 4'd0);
      if (Ready) begin
        expQ.push_back({4'(s % 15 + 1), 16'(16'hC000 + s)});
        expQ.push_back({4'((s + 1) % 15 + 1), 16'(16'hC000 + s + 1)});
        s += 2;
      end
    end
    for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
      @(negedge CLK);
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      if (RfWrite) begin
        expE = expQ.pop_front();
        check("bp_drain_entry", 32'({RfWriteAddr, RfDataIn}), 32'(expE));
      end
    end
    check("bp_left", 32'(expQ.size()), 32'd0);
    @(negedge CLK);
    check("bp_idle_wr", 32'(RfWrite), 32'd0);
    check("bp_idle_count", 32'(Count), 32'd0);

    // Ordered fill: registers 1..15 with data = address
    a = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (RfWrite) wrLog.push_back({RfWriteAddr, RfDataIn});
      if (a <= 15) begin
        drive(1'b1, 4'(a), 16'(a), 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
        if (Ready) a++;
      end else begin
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      end
    end
    check("fill_accepted", 32'(a), 32'd16);
    check("fill_nwrites", 32'(wrLog.size()), 32'd15);
    for (int i = 0; i < wrLog.size() && i < 15; i++) begin
      check($sformatf("fill_wr%0d", i), 32'(wrLog[i]), 32'({4'(i + 1), 16'(i + 1)}));
    end
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fill_rf%0d", i), 32'(rfMem[i]), 32'(i));
    end

    // Reset mid-operation with three queued entries
    @(negedge CLK);
    drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd2, 16'h2222, 4'd0, 4'd0);
    @(negedge CLK);
    drive(1'b1, 4'd8, 16'h8888, 1'b1, 4'd6, 16'h6666, 4'd0, 4'd0);
    @(negedge CLK);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd6, 4'd8);
    #1;
    check("mrst_pre_count", 32'(Count), 32'd3);
    check("mrst_pre_hitA", 32'(FwdHitA), 32'd1);
    check("mrst_pre_wr", 32'(RfWrite), 32'd1);
    @(posedge CLK);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mrst_wr", 32'(RfWrite), 32'd0);
    check("mrst_count", 32'(Count), 32'd0);
    check("mrst_ready", 32'(Ready), 32'd1);
    check("mrst_hitA", 32'(FwdHitA), 32'd0);
    check("mrst_hitB", 32'(FwdHitB), 32'd0);
    check("mrst_waddr", 32'(RfWriteAddr), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      check($sformatf("mrst_post%0d_wr", c), 32'(RfWrite), 32'd0);
      check($sformatf("mrst_post%0d_count", c), 32'(Count), 32'd0);
    end

    // Random stimulus against the reference model
    mq.delete();
    mOutV = 1'b0;
    mOutA = 4'd0;
    mOutD = 16'h0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      check("rnd_ready", 32'(Ready), (mq.size() <= DEPTH - 2) ? 32'd1 : 32'd0);
      check("rnd_count", 32'(Count), 32'(mq.size()));
      check("rnd_wr", 32'(RfWrite), 32'(mOutV));
      check("rnd_waddr", 32'(RfWriteAddr), 32'(mOutA));
      check("rnd_wdata", 32'(RfDataIn), 32'(mOutD));
      modelFwd(ReadAddrA, mh, md);
      check("rnd_hitA", 32'(FwdHitA), 32'(mh));
      check("rnd_dataA", 32'(FwdDataA), 32'(md));
      modelFwd(ReadAddrB, mh, md);
      check("rnd_hitB", 32'(FwdHitB), 32'(mh));
      check("rnd_dataB", 32'(FwdDataB), 32'(md));
      @(posedge CLK);
      modelStep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
